// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with a load/store unit.
// Issues B/H/W/D requests on the data bus, waits for a variable-latency
// response, aligns and extends load data, and publishes a bypass source.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned accesses
// (out_exc=1, no bus request) instead of silently aligning them down.
module mem_access_stage #(
    parameter int XLEN      = 64,
    parameter int ADDR_W    = 64,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_load,
    input  logic                 in_store,
    input  logic [1:0]           in_size,
    input  logic                 in_unsigned,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [XLEN-1:0]      in_wdata,
    input  logic                 in_wb_en,
    input  logic [REG_IDX_W-1:0] in_wd,
    input  logic [XLEN-1:0]      in_alu,
    input  logic [ADDR_W-1:0]    in_pc,
    input  logic                 hold,
    output logic                 dreq_valid,
    output logic                 dreq_write,
    output logic [ADDR_W-1:0]    dreq_addr,
    output logic [1:0]           dreq_size,
    output logic [XLEN/8-1:0]    dreq_strb,
    output logic [XLEN-1:0]      dreq_wdata,
    input  logic                 dresp_ok,
    input  logic [XLEN-1:0]      dresp_rdata,
    output logic                 out_valid,
    output logic                 out_wb_en,
    output logic [REG_IDX_W-1:0] out_wd,
    output logic [XLEN-1:0]      out_data,
    output logic [ADDR_W-1:0]    out_pc,
    output logic                 out_exc,
    output logic                 fwd_valid,
    output logic                 fwd_wb,
    output logic [REG_IDX_W-1:0] fwd_wd,
    output logic [XLEN-1:0]      fwd_data,
    output logic                 fwd_pending
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAITWB = 2'd2} state_t;
    state_t state, state_next;

    logic              accept, is_mem, misalign, issue;
    logic [1:0]        eff_size;
    logic [3:0]        size_m1;
    logic [NB-1:0]     strb_base;
    logic [ADDR_W-1:0] aligned_addr;
    logic [OFF_W-1:0]  off;

    // Entry held while the bus transaction is outstanding
    logic                 h_load, h_unsigned, h_wb_en;
    logic [REG_IDX_W-1:0] h_wd;
    logic [ADDR_W-1:0]    h_pc, h_addr;
    logic [1:0]           h_size;
    logic [OFF_W-1:0]     h_off;
    logic [XLEN-1:0]      rdata_buf;

    logic [XLEN-1:0] load_src, load_shift, load_ext, res_data;
    logic            res_wb;

    assign in_ready = (state == IDLE) && !hold;
    assign accept   = in_valid && in_ready;
    assign is_mem   = in_load || in_store;
    assign eff_size = (XLEN == 32 && in_size == 2'd3) ? 2'd2 : in_size;

    // Byte count minus one and the unshifted strobe pattern for the access size
    always_comb begin
        size_m1   = 4'd0;
        strb_base = '0;
        case (eff_size)
            2'd0:    begin size_m1 = 4'd0; strb_base = NB'(8'h01); end
            2'd1:    begin size_m1 = 4'd1; strb_base = NB'(8'h03); end
            2'd2:    begin size_m1 = 4'd3; strb_base = NB'(8'h0F); end
            default: begin size_m1 = 4'd7; strb_base = NB'(8'hFF); end
        endcase
    end

    assign aligned_addr = in_addr & ~ADDR_W'(size_m1);
    assign off          = aligned_addr[OFF_W-1:0];

`ifdef MISALIGN_TRAP_EN
    assign misalign = is_mem && ((in_addr[3:0] & size_m1) != 4'd0);
`else
    assign misalign = 1'b0;
`endif

    assign issue = accept && is_mem && !misalign;

    // Next-state logic for the request/response handshake
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = REQ;
            REQ:     if (dresp_ok) state_next = hold ? WAITWB : IDLE;
            WAITWB:  if (!hold) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Bus request registers and the held entry, captured when a mem op issues
    always_ff @(posedge clk) begin
        if (rst) begin
            dreq_valid <= 1'b0;
            dreq_write <= 1'b0;
            dreq_addr  <= '0;
            dreq_size  <= 2'd0;
            dreq_strb  <= '0;
            dreq_wdata <= '0;
            h_load     <= 1'b0;
            h_unsigned <= 1'b0;
            h_wb_en    <= 1'b0;
            h_wd       <= '0;
            h_pc       <= '0;
            h_addr     <= '0;
            h_size     <= 2'd0;
            h_off      <= '0;
            rdata_buf  <= '0;
        end else begin
            if (issue) begin
                dreq_valid <= 1'b1;
                dreq_write <= in_store;
                dreq_addr  <= aligned_addr;
                dreq_size  <= eff_size;
                dreq_strb  <= strb_base << off;
                dreq_wdata <= in_wdata << {off, 3'b000};
                h_load     <= in_load;
                h_unsigned <= in_unsigned;
                h_wb_en    <= in_wb_en;
                h_wd       <= in_wd;
                h_pc       <= in_pc;
                h_addr     <= in_addr;
                h_size     <= eff_size;
                h_off      <= off;
            end else if (state == REQ && dresp_ok) begin
                dreq_valid <= 1'b0;
            end
            if (state == REQ && dresp_ok && hold) rdata_buf <= dresp_rdata;
        end
    end

    assign load_src   = (state == WAITWB) ? rdata_buf : dresp_rdata;
    assign load_shift = load_src >> {h_off, 3'b000};

    // Size masking and sign/zero extension of the lane-aligned load data
    always_comb begin
        load_ext = load_shift;
        case (h_size)
            2'd0: load_ext = h_unsigned ? XLEN'(load_shift[7:0])  : XLEN'($signed(load_shift[7:0]));
            2'd1: load_ext = h_unsigned ? XLEN'(load_shift[15:0]) : XLEN'($signed(load_shift[15:0]));
            2'd2: load_ext = h_unsigned ? XLEN'(load_shift[31:0]) : XLEN'($signed(load_shift[31:0]));
            default: load_ext = load_shift;
        endcase
    end

    assign res_data = h_load ? load_ext : XLEN'(h_addr);
    assign res_wb   = h_load && h_wb_en;

    // MEM/WB output register: frozen by hold, otherwise loaded by a pass-through or a completed access
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_wb_en <= 1'b0;
            out_wd    <= '0;
            out_data  <= '0;
            out_pc    <= '0;
            out_exc   <= 1'b0;
        end else if (!hold) begin
            if (accept && !issue) begin
                out_valid <= 1'b1;
                out_wb_en <= in_wb_en && !misalign;
                out_wd    <= in_wd;
                out_data  <= in_alu;
                out_pc    <= in_pc;
                out_exc   <= misalign;
            end else if ((state == REQ && dresp_ok) || state == WAITWB) begin
                out_valid <= 1'b1;
                out_wb_en <= res_wb;
                out_wd    <= h_wd;
                out_data  <= res_data;
                out_pc    <= h_pc;
                out_exc   <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Bypass source: the entry being accepted, or the held entry while the bus is busy
    always_comb begin
        fwd_valid   = 1'b0;
        fwd_wb      = 1'b0;
        fwd_wd      = '0;
        fwd_data    = '0;
        fwd_pending = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                if (accept) begin
                    fwd_valid   = 1'b1;
                    fwd_wb      = in_wb_en && !in_store && !misalign && (in_wd != '0);
                    fwd_wd      = in_wd;
                    fwd_data    = in_alu;
                    fwd_pending = in_load && !misalign;
                end
            end else begin
                fwd_valid   = 1'b1;
                fwd_wb      = h_wb_en && h_load && (h_wd != '0);
                fwd_wd      = h_wd;
                fwd_pending = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized self-checking bench for mem_access_stage
// (default build, 64-bit datapath). Expected results come from a
// transaction-level model of the load/store rules.
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_load, in_store, in_unsigned, in_wb_en, hold;
    logic [1:0]  in_size;
    logic [63:0] in_addr, in_wdata, in_alu, in_pc;
    logic [4:0]  in_wd;
    logic        dreq_valid, dreq_write;
    logic [63:0] dreq_addr, dreq_wdata;
    logic [1:0]  dreq_size;
    logic [7:0]  dreq_strb;
    logic        dresp_ok;
    logic [63:0] dresp_rdata;
    logic        out_valid, out_wb_en, out_exc;
    logic [4:0]  out_wd;
    logic [63:0] out_data, out_pc;
    logic        fwd_valid, fwd_wb, fwd_pending;
    logic [4:0]  fwd_wd;
    logic [63:0] fwd_data;

    int checkCount = 0;
    int errorCount = 0;

    mem_access_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_wb_en(in_wb_en), .in_wd(in_wd), .in_alu(in_alu), .in_pc(in_pc), .hold(hold),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strb(dreq_strb), .dreq_wdata(dreq_wdata),
        .dresp_ok(dresp_ok), .dresp_rdata(dresp_rdata),
        .out_valid(out_valid), .out_wb_en(out_wb_en), .out_wd(out_wd), .out_data(out_data),
        .out_pc(out_pc), .out_exc(out_exc),
        .fwd_valid(fwd_valid), .fwd_wb(fwd_wb), .fwd_wd(fwd_wd), .fwd_data(fwd_data),
        .fwd_pending(fwd_pending)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: pick the addressed bytes out of a full word and extend them
    function automatic logic [63:0] refLoad(input logic [63:0] rdata, input logic [63:0] addr,
                                            input int bytes, input bit uns);
        logic [63:0] val, mask;
        int off;
        off = int'((addr & ~64'(bytes - 1)) % 8);
        val = rdata >> (8 * off);
        if (bytes < 8) begin
            mask = (64'd1 << (8 * bytes)) - 64'd1;
            val  = val & mask;
            if (!uns && val[8 * bytes - 1]) val = val | ~mask;
        end
        return val;
    endfunction

    // Drive one instruction through the stage and check everything it should produce
    task automatic applyStimulus(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] alu, input logic [4:0] wd, input bit wb,
                                 input int lat, input int hc, input logic [63:0] rdata);
        int bytes, off;
        logic [63:0] pc, expData, laneMask, expAddr;
        logic [7:0] expStrb;
        bit expWb;
        pc = {$urandom, $urandom};
        bytes = 1 << sz;
        expAddr = addr & ~64'(bytes - 1);
        off = int'(expAddr % 8);
        expStrb = 8'(((1 << bytes) - 1) << off);
        laneMask = '0;
        for (int b = 0; b < 8; b++) if (expStrb[b]) laneMask[8*b +: 8] = 8'hFF;
        expData = ld ? refLoad(rdata, addr, bytes, uns) : (st ? addr : alu);
        expWb = st ? 1'b0 : wb;

        in_valid = 1; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
        in_addr = addr; in_wdata = wdata; in_alu = alu; in_wd = wd; in_wb_en = wb;
        in_pc = pc; hold = 0; dresp_ok = 0;
        @(negedge clk);
        checkOutput("ready_idle", in_ready, 1);
        checkOutput("fwd_valid", fwd_valid, 1);
        checkOutput("fwd_wd", fwd_wd, wd);
        checkOutput("fwd_data", fwd_data, alu);
        checkOutput("fwd_pend", fwd_pending, ld);
        checkOutput("fwd_wb", fwd_wb, wb && !st && wd != 0);
        @(posedge clk); #1;
        in_valid = 0;

        if (ld || st) begin
            for (int c = 0; c <= lat; c++) begin
                if (c == lat) begin
                    dresp_ok = 1; dresp_rdata = rdata; hold = (hc > 0);
                end
                @(negedge clk);
                checkOutput("dreq_valid", dreq_valid, 1);
                checkOutput("dreq_write", dreq_write, st);
                checkOutput("dreq_addr", dreq_addr, expAddr);
                checkOutput("dreq_size", dreq_size, sz);
                checkOutput("dreq_strb", dreq_strb, expStrb);
                if (st) checkOutput("dreq_wdata", dreq_wdata & laneMask, (wdata << (8 * off)) & laneMask);
                checkOutput("ready_busy", in_ready, 0);
                checkOutput("busy_pend", fwd_pending, 1);
                checkOutput("busy_fwdwb", fwd_wb, ld && wb && wd != 0);
                checkOutput("busy_outv", out_valid, 0);
                @(posedge clk); #1;
            end
            dresp_ok = 0;
            dresp_rdata = {$urandom, $urandom};
            if (hc > 0) begin
                for (int h = 1; h < hc; h++) begin
                    @(negedge clk);
                    checkOutput("hold_outv", out_valid, 0);
                    checkOutput("hold_ready", in_ready, 0);
                    @(posedge clk); #1;
                end
                hold = 0;
                @(negedge clk);
                checkOutput("waitwb_ready", in_ready, 0);
                @(posedge clk); #1;
            end
            @(negedge clk);
            checkOutput("done_dreqv", dreq_valid, 0);
            checkOutput("done_ready", in_ready, 1);
            checkOutput("mem_outv", out_valid, 1);
            checkOutput("mem_data", out_data, expData);
            checkOutput("mem_wb", out_wb_en, expWb);
            checkOutput("mem_wd", out_wd, wd);
            checkOutput("mem_pc", out_pc, pc);
            checkOutput("mem_exc", out_exc, 0);
        end else begin
            @(negedge clk);
            checkOutput("alu_outv", out_valid, 1);
            checkOutput("alu_data", out_data, expData);
            checkOutput("alu_wb", out_wb_en, expWb);
            checkOutput("alu_wd", out_wd, wd);
            checkOutput("alu_pc", out_pc, pc);
            checkOutput("alu_dreqv", dreq_valid, 0);
            if (hc > 0) begin
                hold = 1;
                for (int h = 0; h < hc; h++) begin
                    @(posedge clk); #1;
                    @(negedge clk);
                    checkOutput("frz_outv", out_valid, 1);
                    checkOutput("frz_data", out_data, expData);
                    checkOutput("frz_ready", in_ready, 0);
                end
                hold = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_load = 0; in_store = 0; in_size = 0; in_unsigned = 0;
        in_addr = 0; in_wdata = 0; in_alu = 0; in_wd = 0; in_wb_en = 0; in_pc = 0;
        hold = 0; dresp_ok = 0; dresp_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checkOutput("rst_outv", out_valid, 0);
        checkOutput("rst_dreqv", dreq_valid, 0);
        checkOutput("rst_fwdv", fwd_valid, 0);
        checkOutput("rst_exc", out_exc, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed cases
        applyStimulus(0, 0, 2'd3, 0, 64'h0, 64'h0, 64'h1234, 5'd5, 1, 0, 0, 64'h0);
        applyStimulus(1, 0, 2'd0, 0, 64'h1003, 64'h0, 64'h1003, 5'd7, 1, 0, 0, 64'h8000_0000);
        applyStimulus(1, 0, 2'd1, 1, 64'h1002, 64'h0, 64'h1002, 5'd9, 1, 2, 0, 64'h1122_3344_BEEF_5566);
        applyStimulus(0, 1, 2'd0, 0, 64'h1005, 64'hAB, 64'h1005, 5'd3, 1, 0, 0, 64'h0);
        applyStimulus(1, 0, 2'd2, 0, 64'h2004, 64'h0, 64'h2004, 5'd4, 1, 1, 2, 64'h9ABC_DEF0_1234_5678);
        applyStimulus(0, 0, 2'd0, 0, 64'h0, 64'h0, 64'hCAFE, 5'd0, 1, 0, 1, 64'h0);

        // Reset in the middle of an outstanding request; the late response must be ignored
        in_valid = 1; in_load = 1; in_store = 0; in_size = 2'd3; in_addr = 64'h3000;
        in_wd = 5'd6; in_wb_en = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        checkOutput("mid_dreqv", dreq_valid, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; dresp_ok = 1; dresp_rdata = 64'hDEAD;
        @(negedge clk);
        checkOutput("mid_rst_dreqv", dreq_valid, 0);
        checkOutput("mid_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        dresp_ok = 0;
        @(negedge clk);
        checkOutput("late_resp_outv", out_valid, 0);
        @(posedge clk); #1;

        // Randomized mix of ALU ops, loads and stores
        for (int n = 0; n < 60; n++) begin
            int kind;
            logic [1:0] sz;
            logic [63:0] addr;
            kind = $urandom_range(0, 2);
            sz = 2'($urandom_range(0, 3));
            addr = {32'h0, $urandom};
            applyStimulus(kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)), addr,
                          {$urandom, $urandom}, (kind == 0) ? {$urandom, $urandom} : addr,
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
                          {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
